// File: rtl/joy_pkg.sv
// Shared constants for the serial joystick scanner: frame size, idle word,
// FSM states and the serial-bit to player-bit routing table.
package joy_pkg;

   localparam int unsigned NBITS    = 24;
   localparam logic [11:0] JOY_IDLE = 12'hFFF;

   typedef enum logic [1:0] {
      LOAD,
      SHIFT,
      GAP
   } joy_state_e;

   typedef struct packed {
      logic       player;   // 0: joystick1, 1: joystick2
      logic [3:0] idx;
   } joy_dst_t;

   // Indexed by serial bit position; bit 0 is the first bit out of the chain.
   localparam joy_dst_t BIT_MAP [NBITS] = '{
      '{1'b0, 4'd8},  '{1'b0, 4'd6},  '{1'b0, 4'd5},  '{1'b0, 4'd4},
      '{1'b0, 4'd3},  '{1'b0, 4'd2},  '{1'b0, 4'd1},  '{1'b0, 4'd0},
      '{1'b1, 4'd8},  '{1'b1, 4'd6},  '{1'b1, 4'd5},  '{1'b1, 4'd4},
      '{1'b1, 4'd3},  '{1'b1, 4'd2},  '{1'b1, 4'd1},  '{1'b1, 4'd0},
      '{1'b1, 4'd10}, '{1'b1, 4'd11}, '{1'b1, 4'd9},  '{1'b1, 4'd7},
      '{1'b0, 4'd10}, '{1'b0, 4'd11}, '{1'b0, 4'd9},  '{1'b0, 4'd7}
   };

endpackage

// File: rtl/joy_serial_ctrl_tick_div.sv
// Clock-enable generator: one-cycle tick every DIV clk cycles, counter
// cleared by reset so the first tick lands DIV cycles after release.
module tick_div #(
   parameter int unsigned DIV = 16
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (tick) cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/joy_serial_ctrl.sv
// Scans the external PISO joystick chain and commits each 24-bit frame,
// optionally debounced, as two active-low 12-bit player words.
module joy_serial_ctrl
   import joy_pkg::*;
#(
   parameter int unsigned CLK_DIV   = 16,
   parameter int unsigned GAP_TICKS = 2,
   parameter bit          DEBOUNCE  = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   output logic        joy_clk,
   output logic        joy_load,
   input  logic        joy_data,
   output logic [11:0] joystick1,
   output logic [11:0] joystick2,
   output logic        frame_valid
);

   localparam int unsigned GW = $clog2(GAP_TICKS + 1);

   logic             tick;
   logic [1:0]       sync_q;
   joy_state_e       state_q, state_d;
   logic [GW-1:0]    cnt_q, cnt_d;
   logic             half_q, half_d;
   logic [4:0]       bit_q, bit_d;
   logic [NBITS-1:0] shadow_q, shadow_d;
   logic [NBITS-1:0] raw_q, raw_d;
   logic [11:0]      j1_q, j1_d, j2_q, j2_d;
   logic [11:0]      map_j1, map_j2;
   logic             fv_q, fv_d;
   logic             jclk_q, jclk_d;
   logic             jload_q, jload_d;

   tick_div #(.DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   always_comb begin
      map_j1 = JOY_IDLE;
      map_j2 = JOY_IDLE;
      for (int unsigned i = 0; i < NBITS; i++) begin
         if (BIT_MAP[i].player) map_j2[BIT_MAP[i].idx] = shadow_q[i];
         else                   map_j1[BIT_MAP[i].idx] = shadow_q[i];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      half_d   = half_q;
      bit_d    = bit_q;
      shadow_d = shadow_q;
      raw_d    = raw_q;
      j1_d     = j1_q;
      j2_d     = j2_q;
      fv_d     = 1'b0;
      jclk_d   = jclk_q;
      jload_d  = jload_q;
      if (tick) begin
         unique case (state_q)
            LOAD: begin
               jload_d = 1'b0;
               jclk_d  = 1'b0;
               if (cnt_q != '0) begin
                  state_d = SHIFT;
                  cnt_d   = '0;
                  half_d  = 1'b0;
                  bit_d   = '0;
               end else begin
                  cnt_d = cnt_q + GW'(1);
               end
            end
            SHIFT: begin
               jload_d = 1'b1;
               if (!half_q) begin
                  jclk_d = 1'b0;
                  half_d = 1'b1;
               end else begin
                  // Sample before the rising shift clock advances the chain.
                  shadow_d[bit_q] = sync_q[1];
                  jclk_d = 1'b1;
                  half_d = 1'b0;
                  if (bit_q == 5'(NBITS - 1)) begin
                     state_d = GAP;
                     cnt_d   = '0;
                  end else begin
                     bit_d = bit_q + 5'd1;
                  end
               end
            end
            GAP: begin
               jclk_d  = 1'b0;
               jload_d = 1'b1;
               if (cnt_q == '0) begin
                  raw_d = shadow_q;
                  if (!DEBOUNCE || (shadow_q == raw_q)) begin
                     j1_d = map_j1;
                     j2_d = map_j2;
                     fv_d = 1'b1;
                  end
               end
               if (cnt_q == GW'(GAP_TICKS - 1)) begin
                  state_d = LOAD;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + GW'(1);
               end
            end
            default: state_d = LOAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q   <= '1;
         state_q  <= LOAD;
         cnt_q    <= '0;
         half_q   <= 1'b0;
         bit_q    <= '0;
         shadow_q <= '1;
         raw_q    <= '1;
         j1_q     <= JOY_IDLE;
         j2_q     <= JOY_IDLE;
         fv_q     <= 1'b0;
         jclk_q   <= 1'b0;
         jload_q  <= 1'b1;
      end else begin
         sync_q   <= {sync_q[0], joy_data};
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         half_q   <= half_d;
         bit_q    <= bit_d;
         shadow_q <= shadow_d;
         raw_q    <= raw_d;
         j1_q     <= j1_d;
         j2_q     <= j2_d;
         fv_q     <= fv_d;
         jclk_q   <= jclk_d;
         jload_q  <= jload_d;
      end
   end

   assign joy_clk     = jclk_q;
   assign joy_load    = jload_q;
   assign joystick1   = j1_q;
   assign joystick2   = j2_q;
   assign frame_valid = fv_q;

endmodule

// File: tb/tb_joy_serial_ctrl.sv
// Bench: three scanners (fast/no-debounce, debounced, minimum divider) each
// fed by a behavioural shift-register chain driven from a pattern variable.
module tb_joy_serial_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        jclk [3];
   logic        jload [3];
   logic        jdata [3];
   logic        fv [3];
   logic [11:0] j1 [3];
   logic [11:0] j2 [3];
   logic [23:0] pat [3];
   logic [4:0]  idx [3];
   logic        jclk_prev [3];
   int unsigned cyc = 0;
   int unsigned fvcnt_b = 0;
   int          checks = 0;
   int          errors = 0;

   joy_serial_ctrl #(.CLK_DIV(4), .GAP_TICKS(2), .DEBOUNCE(1'b0)) dut_a (
      .clk(clk), .reset(reset), .joy_clk(jclk[0]), .joy_load(jload[0]),
      .joy_data(jdata[0]), .joystick1(j1[0]), .joystick2(j2[0]), .frame_valid(fv[0]));
   joy_serial_ctrl #(.CLK_DIV(4), .GAP_TICKS(2), .DEBOUNCE(1'b1)) dut_b (
      .clk(clk), .reset(reset), .joy_clk(jclk[1]), .joy_load(jload[1]),
      .joy_data(jdata[1]), .joystick1(j1[1]), .joystick2(j2[1]), .frame_valid(fv[1]));
   joy_serial_ctrl #(.CLK_DIV(2), .GAP_TICKS(1), .DEBOUNCE(1'b0)) dut_c (
      .clk(clk), .reset(reset), .joy_clk(jclk[2]), .joy_load(jload[2]),
      .joy_data(jdata[2]), .joystick1(j1[2]), .joystick2(j2[2]), .frame_valid(fv[2]));

   // Chain model: parallel load while joy_load is low, advance one bit per
   // rising joy_clk; bit 0 of the frame is pattern bit 23.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (fv[1]) fvcnt_b <= fvcnt_b + 1;
      for (int g = 0; g < 3; g++) begin
         if (reset)                 idx[g] <= 5'd24;
         else if (!jload[g])        idx[g] <= 5'd0;
         else if (jclk[g] && !jclk_prev[g] && idx[g] != 5'd24) idx[g] <= idx[g] + 5'd1;
         jclk_prev[g] <= reset ? 1'b0 : jclk[g];
      end
   end

   always_comb begin
      for (int g = 0; g < 3; g++)
         jdata[g] = (idx[g] < 5'd24) ? pat[g][5'd23 - idx[g]] : 1'b1;
   end

   function automatic logic [23:0] decode(input logic [23:0] p);
      logic [23:0] s;
      logic [11:0] a, b;
      for (int i = 0; i < 24; i++) s[i] = p[23 - i];
      a = '1; b = '1;
      a[8] = s[0];  a[6] = s[1];  a[5] = s[2];  a[4] = s[3];
      a[3] = s[4];  a[2] = s[5];  a[1] = s[6];  a[0] = s[7];
      b[8] = s[8];  b[6] = s[9];  b[5] = s[10]; b[4] = s[11];
      b[3] = s[12]; b[2] = s[13]; b[1] = s[14]; b[0] = s[15];
      b[10] = s[16]; b[11] = s[17]; b[9] = s[18]; b[7] = s[19];
      a[10] = s[20]; a[11] = s[21]; a[9] = s[22]; a[7] = s[23];
      return {a, b};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s timeout actual=expired required=event", name);
   endtask

   task automatic wait_fv(input int g, output int unsigned at);
      int n = 1;
      @(negedge clk);
      while (!fv[g] && n < 3000) begin @(negedge clk); n++; end
      if (!fv[g]) timeout($sformatf("wait_fv%0d", g));
      at = cyc;
   endtask

   task automatic wait_idx(input int g, input logic [4:0] v);
      int n = 0;
      while (idx[g] != v && n < 3000) begin @(negedge clk); n++; end
      if (idx[g] != v) timeout($sformatf("wait_idx%0d", g));
   endtask

   task automatic wait_frame_end(input int g);
      int n = 0;
      while (idx[g] == 5'd24 && n < 3000) begin @(negedge clk); n++; end
      while (idx[g] != 5'd24 && n < 3000) begin @(negedge clk); n++; end
      if (n >= 3000) timeout($sformatf("frame_end%0d", g));
   endtask

   task automatic wait_load(input int g);
      int n = 0;
      while (!jload[g] && n < 3000) begin @(negedge clk); n++; end
      while (jload[g] && n < 3000) begin @(negedge clk); n++; end
      if (n >= 3000) timeout($sformatf("wait_load%0d", g));
   endtask

   typedef struct {
      logic [23:0] pat;
      logic [11:0] ej1;
      logic [11:0] ej2;
   } vec_t;

   vec_t        vecs [9];
   int unsigned t, t_prev, c0;
   int          first_load [3];
   int          n, run, minhi, minlo;
   logic        prev, first, hold_bad;
   logic [23:0] oldp, newp, mixe;

   initial begin
      vecs[0] = '{24'hA53C0F, 12'hFA5, 12'h03C};
      vecs[1] = '{24'hFFFFFF, 12'hFFF, 12'hFFF};
      vecs[2] = '{24'h000000, 12'h000, 12'h000};
      vecs[3] = '{24'h7FFFFF, 12'hEFF, 12'hFFF};
      vecs[4] = '{24'hFFFFF0, 12'h17F, 12'hFFF};
      vecs[5] = '{24'hFFFF0F, 12'hFFF, 12'h17F};
      vecs[6] = '{24'h00FFFF, 12'hE80, 12'hFFF};
      vecs[7] = '{24'hFF00FF, 12'hFFF, 12'hE80};
      vecs[8] = '{24'h123456, 12'hA12, 12'h8B4};
      for (int g = 0; g < 3; g++) pat[g] = 24'hFFFFFF;

      // Reset state and first load edge
      reset = 1'b1;
      repeat (10) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("rst_j1_%0d", g), j1[g], 12'hFFF);
         chk($sformatf("rst_j2_%0d", g), j2[g], 12'hFFF);
         chk($sformatf("rst_load_%0d", g), jload[g], 1'b1);
         chk($sformatf("rst_clk_%0d", g), jclk[g], 1'b0);
         chk($sformatf("rst_fv_%0d", g), fv[g], 1'b0);
         first_load[g] = 0;
      end
      reset = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         for (int g = 0; g < 3; g++)
            if (!jload[g] && first_load[g] == 0) first_load[g] = k;
      end
      chk("first_load_a", first_load[0], 4);
      chk("first_load_b", first_load[1], 4);
      chk("first_load_c", first_load[2], 2);

      // Pattern decode, CLK_DIV=4
      wait_fv(0, t_prev);
      for (int i = 0; i < 9; i++) begin
         pat[0] = vecs[i].pat;
         wait_fv(0, t);
         chk($sformatf("a_j1_v%0d", i), j1[0], vecs[i].ej1);
         chk($sformatf("a_j2_v%0d", i), j2[0], vecs[i].ej2);
         chk($sformatf("a_period_v%0d", i), t - t_prev, 208);
         t_prev = t;
         @(negedge clk);
         chk($sformatf("a_fv_pulse_v%0d", i), fv[0], 1'b0);
      end

      // Minimum divider
      wait_fv(2, t_prev);
      for (int i = 0; i < 9; i++) begin
         pat[2] = vecs[i].pat;
         wait_fv(2, t);
         chk($sformatf("c_j1_v%0d", i), j1[2], vecs[i].ej1);
         chk($sformatf("c_j2_v%0d", i), j2[2], vecs[i].ej2);
         chk($sformatf("c_period_v%0d", i), t - t_prev, 102);
         t_prev = t;
         @(negedge clk);
      end
      prev = jclk[2]; run = 0; first = 1'b1; minhi = 999; minlo = 999;
      for (int k = 0; k < 204; k++) begin
         @(negedge clk);
         if (jclk[2] == prev) run++;
         else begin
            if (!first) begin
               if (prev) minhi = (run < minhi) ? run : minhi;
               else      minlo = (run < minlo) ? run : minlo;
            end
            first = 1'b0; run = 1; prev = jclk[2];
         end
      end
      chk("c_clk_high_min", minhi, 2);
      chk("c_clk_low_ge2", (minlo >= 2 && minlo != 999), 1);

      // Debounce: a one-frame glitch is never committed
      wait_frame_end(1);
      pat[1] = 24'h7FFFFF;
      wait_load(1);
      c0 = fvcnt_b;
      wait_frame_end(1);
      pat[1] = 24'hFFFFFF;
      wait_load(1);
      chk("db_glitch_j1", j1[1], 12'hFFF);
      wait_frame_end(1);
      wait_load(1);
      chk("db_glitch_nofv", fvcnt_b - c0, 0);
      chk("db_glitch_j1b", j1[1], 12'hFFF);
      // Two identical frames commit after the second
      wait_frame_end(1);
      pat[1] = 24'h7FFFFF;
      wait_load(1);
      c0 = fvcnt_b;
      wait_frame_end(1);
      wait_load(1);
      chk("db_first_nofv", fvcnt_b - c0, 0);
      chk("db_first_j1", j1[1], 12'hFFF);
      wait_frame_end(1);
      wait_load(1);
      chk("db_second_fv", fvcnt_b - c0, 1);
      chk("db_second_j1", j1[1], 12'hEFF);
      chk("db_second_j2", j2[1], 12'hFFF);

      // Atomic commit: data changes after bit 12 is sampled
      oldp = vecs[8].pat;
      newp = 24'hA53C0F;
      mixe = decode({oldp[23:11], newp[10:0]});
      wait_idx(0, 5'd13);
      pat[0] = newp;
      hold_bad = 1'b0;
      n = 0;
      while (!fv[0] && n < 400) begin
         @(negedge clk);
         n++;
         if (!fv[0] && (j1[0] != vecs[8].ej1 || j2[0] != vecs[8].ej2)) hold_bad = 1'b1;
      end
      chk("atomic_hold", hold_bad, 1'b0);
      chk("atomic_fv", fv[0], 1'b1);
      chk("atomic_j1", j1[0], mixe[23:12]);
      chk("atomic_j2", j2[0], mixe[11:0]);
      wait_fv(0, t);
      chk("atomic_next_j1", j1[0], 12'hFA5);
      chk("atomic_next_j2", j2[0], 12'h03C);

      // Mid-frame reset
      pat[0] = 24'h000000;
      wait_fv(0, t);
      wait_fv(0, t);
      chk("mr_pre_j1", j1[0], 12'h000);
      chk("mr_pre_j2", j2[0], 12'h000);
      wait_idx(0, 5'd10);
      pat[0] = 24'hA53C0F;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mr_j1", j1[0], 12'hFFF);
      chk("mr_j2", j2[0], 12'hFFF);
      chk("mr_load", jload[0], 1'b1);
      chk("mr_clk", jclk[0], 1'b0);
      chk("mr_fv", fv[0], 1'b0);
      n = 0;
      first_load[0] = 0;
      while (!fv[0] && n < 400) begin
         @(negedge clk);
         n++;
         if (!jload[0] && first_load[0] == 0) first_load[0] = n;
      end
      chk("mr_first_load", first_load[0], 4);
      chk("mr_fv_delay", n, 204);
      chk("mr_new_j1", j1[0], 12'hFA5);
      chk("mr_new_j2", j2[0], 12'h03C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/joy_serial_ctrl.md
# joy_serial_ctrl

Serial joystick scanner for the JAMMA/DB9 adapter: drives the external parallel-in/serial-out shift-register chain (load, clock) and deserialises its 24-bit frame into two 12-bit active-low player words. It runs from the core pixel clock using an internal clock-enable divider, so it replaces any logic clocked by a derived signal. Outputs feed the arcade core's joystick, coin, start and reset inputs, and the multiboot trigger.

## Interface
Parameters:
- CLK_DIV, 16: clk cycles per tick. One tick is half a shift-clock period. Legal values are ≥ 2.
- GAP_TICKS, 2: idle ticks between frames. Legal values are ≥ 1.
- DEBOUNCE, 1: 1 means a new frame is committed only if it equals the previous raw frame. 0 means every frame is committed.

Ports:
- clk  in  1  core clock (pclk). Every register is clocked on its rising edge.
- reset  in  1  synchronous, active-high.
- joy_clk  out  1  shift clock to the chain.
- joy_load  out  1  parallel load to the chain, active low.
- joy_data  in  1  serial data from the chain. Asynchronous to clk.
- joystick1  out  12  player 1 word, active low.
- joystick2  out  12  player 2 word, active low.
- frame_valid  out  1  one-clk pulse, asserted on the cycle joystick1/joystick2 are committed.

## Operation
- Reset values: joy_clk=0, joy_load=1, joystick1=12'hFFF, joystick2=12'hFFF, frame_valid=0. After reset the state is LOAD with the divider at 0.
- Tick: asserted for one clk every CLK_DIV cycles. All FSM changes and pin changes happen on tick cycles only.
- joy_data passes through a 2-flop synchroniser before use.
- FSM:
  - LOAD (2 ticks): joy_load=0, joy_clk=0.
  - SHIFT (24 bits × 2 ticks): joy_load=1. First tick of each bit: joy_clk=0. Second tick of each bit: sample the synchronised joy_data into shadow[bit], then drive joy_clk=1.
  - GAP (GAP_TICKS ticks): joy_clk=0, joy_load=1.
  - GAP returns to LOAD.
- Bit counter is 5 bits and counts 0..23. SHIFT exits after bit 23; the counter never wraps within a frame.
- Serial bit index → destination:
  - bits 0–7: joystick1[8,6,5,4,3,2,1,0]
  - bits 8–15: joystick2[8,6,5,4,3,2,1,0]
  - bits 16–19: joystick2[10,11,9,7]
  - bits 20–23: joystick1[10,11,9,7]
- Commit happens on the GAP entry tick. It is atomic: both words update in the same clk and frame_valid pulses in that clk.
  - DEBOUNCE=1: commit only when shadow equals the previous raw frame. The raw frame is always stored. No commit means no frame_valid pulse.
- A partial frame never reaches the outputs.
- Reset mid-frame: the shadow is discarded, outputs return to 12'hFFF, and scanning restarts at LOAD.

## Timing
- Frame length: (2 + 48 + GAP_TICKS) ticks = 52 × CLK_DIV clk cycles at the defaults.
- Latency:
  - DEBOUNCE=0: from the sample of bit 23 to the output update is 1 tick.
  - DEBOUNCE=1: a press changes the outputs 1 frame plus 1 tick after it is first sampled.
- joy_data setup: the input must be stable for ≥ 3 clk before a sampling tick (synchroniser depth + 1).
- Worst case after reset is 2 frames until the first frame_valid (with DEBOUNCE=1).

## Structure
- Package joy_pkg holds:
  - NBITS = 24.
  - The bit-map constant array (serial index → {player, bit}).
  - FSM state enum {LOAD, SHIFT, GAP}.
  - JOY_IDLE = 12'hFFF.
- Sub-module tick_div (parameter DIV, ports clk, reset, tick). It is reused for the other clock enables in the design.
- The top-level FSM, counters, shadow, raw-frame and output registers stay in joy_serial_ctrl.

## Test plan
- Reset behaviour: hold reset 10 cycles → outputs 12'hFFF, joy_load=1, joy_clk=0. The first joy_load falling edge appears on the first tick after reset is released.
- Pattern decode (DEBOUNCE=0, CLK_DIV=4): the model shifts 24'hA5_3C_0F with MSB of the first byte as serial bit 0 → outputs match the bit map exactly. frame_valid occurs once per 208 clk.
- Debounce (DEBOUNCE=1): frame N has bit 0 low, frame N+1 has bit 0 high → no commit and no frame_valid. Two consecutive frames with bit 0 low → joystick1[8]=0 after the second frame.
- Atomic commit: the data changes during bit 12 → no output change until the GAP entry tick, and both words change in the same clk.
- Mid-frame reset: assert reset at bit 10 → outputs 12'hFFF next clk and the next frame restarts at LOAD. Stale shadow bits are never committed.
- Minimum divider (CLK_DIV=2, GAP_TICKS=1): frame length is 102 clk and the decode is still correct. The joy_clk high and low phases are each ≥ 2 clk.
